uart_avm_ctrl: RTL and testbench

UART_AVM_CTRL -- requirements
Module: uart_avm_ctrl

---
 rtl/uart_avm_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_avm_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_avm_ctrl.sv
// uart_avm_ctrl
//   Bridges a byte-stream TX/RX interface to a UART-style Avalon-MM slave.
//   The controller polls the slave STATUS word. RX_OK is bit 7 and TX_OK is
//   bit 6. It then moves one byte per poll: it reads the RX data word into
//   the RX FIFO, or writes the TX FIFO head to the TX data word. When both
//   directions are ready at once, a round-robin flag alternates between them,
//   starting with RX.
//
// Parameters
//   TX_DEPTH  TX byte FIFO depth (power of 2, >= 2)
//   RX_DEPTH  RX byte FIFO depth (power of 2, >= 2)
//
// Ports
//   avm_clk, avm_rst       clock, synchronous active-high reset
//   avm_address/read/write/writedata   Avalon-MM master request (registered)
//   avm_readdata, avm_waitrequest      Avalon-MM slave response
//   i_tx_data/i_tx_valid/o_tx_ready    TX byte push handshake
//   o_rx_data/o_rx_valid/i_rx_ready    RX byte pop handshake
//   o_busy                 an Avalon transfer is outstanding
//   o_timeout              sticky stall-abort flag (only with the macro below)
//
// Build option
//   UART_AVM_CTRL_TIMEOUT_EN  aborts any transfer that is stalled by
//                             waitrequest for 255 consecutive cycles.
module uart_avm_ctrl #(
   parameter int TX_DEPTH = 4,
   parameter int RX_DEPTH = 4
) (
   input  logic        avm_clk,
   input  logic        avm_rst,
   output logic [4:0]  avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   input  logic        avm_waitrequest,
   input  logic [7:0]  i_tx_data,
   input  logic        i_tx_valid,
   output logic        o_tx_ready,
   output logic [7:0]  o_rx_data,
   output logic        o_rx_valid,
   input  logic        i_rx_ready,
   output logic        o_busy
`ifdef UART_AVM_CTRL_TIMEOUT_EN
   ,
   output logic        o_timeout
`endif
);

   localparam int TXAW = $clog2(TX_DEPTH);
   localparam int RXAW = $clog2(RX_DEPTH);
   localparam logic [TXAW:0] TX_FULL = (TXAW+1)'(TX_DEPTH);
   localparam logic [RXAW:0] RX_FULL = (RXAW+1)'(RX_DEPTH);
   localparam logic [4:0] ADDR_RX     = 5'd0;
   localparam logic [4:0] ADDR_TX     = 5'd4;
   localparam logic [4:0] ADDR_STATUS = 5'd8;

   typedef enum logic [1:0] {S_IDLE, S_POLL, S_RX_READ, S_TX_WRITE} state_t;

   state_t          r_state;
   logic            r_rr_tx;   // 0: RX wins the next tie, 1: TX wins
   logic            w_abort;

   logic [7:0]      r_tx_mem [TX_DEPTH];
   logic [TXAW-1:0] r_tx_wptr, r_tx_rptr;
   logic [TXAW:0]   r_tx_cnt;
   logic            w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;

   logic [7:0]      r_rx_mem [RX_DEPTH];
   logic [RXAW-1:0] r_rx_wptr, r_rx_rptr;
   logic [RXAW:0]   r_rx_cnt;
   logic            w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;

   logic            w_rx_go, w_tx_go;
   logic            w_unused_rd;

   assign w_unused_rd = ^avm_readdata[31:8];

   assign o_busy = avm_read | avm_write;

   // ---------------- TX FIFO ----------------
   assign w_tx_full  = (r_tx_cnt == TX_FULL);
   assign w_tx_empty = (r_tx_cnt == '0);
   assign o_tx_ready = ~w_tx_full;
   assign w_tx_push  = i_tx_valid & ~w_tx_full;
   assign w_tx_pop   = (r_state == S_TX_WRITE) & avm_write & ~avm_waitrequest;

   always_ff @(posedge avm_clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wptr] <= i_tx_data;
   end

   always_ff @(posedge avm_clk) begin
      if (avm_rst) begin
         r_tx_wptr <= '0;
         r_tx_rptr <= '0;
         r_tx_cnt  <= '0;
      end else begin
         if (w_tx_push) r_tx_wptr <= r_tx_wptr + TXAW'(1);
         if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + TXAW'(1);
         case ({w_tx_push, w_tx_pop})
            2'b10:   r_tx_cnt <= r_tx_cnt + (TXAW+1)'(1);
            2'b01:   r_tx_cnt <= r_tx_cnt - (TXAW+1)'(1);
            default: r_tx_cnt <= r_tx_cnt;
         endcase
      end
   end

   // ---------------- RX FIFO ----------------
   assign w_rx_full  = (r_rx_cnt == RX_FULL);
   assign w_rx_empty = (r_rx_cnt == '0);
   assign o_rx_valid = ~w_rx_empty;
   assign o_rx_data  = r_rx_mem[r_rx_rptr];
   assign w_rx_pop   = ~w_rx_empty & i_rx_ready;
   // Space was confirmed at poll time and only pops happen meanwhile.
   assign w_rx_push  = (r_state == S_RX_READ) & avm_read & ~avm_waitrequest;

   always_ff @(posedge avm_clk) begin
      if (w_rx_push) r_rx_mem[r_rx_wptr] <= avm_readdata[7:0];
   end

   always_ff @(posedge avm_clk) begin
      if (avm_rst) begin
         r_rx_wptr <= '0;
         r_rx_rptr <= '0;
         r_rx_cnt  <= '0;
      end else begin
         if (w_rx_push) r_rx_wptr <= r_rx_wptr + RXAW'(1);
         if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + RXAW'(1);
         case ({w_rx_push, w_rx_pop})
            2'b10:   r_rx_cnt <= r_rx_cnt + (RXAW+1)'(1);
            2'b01:   r_rx_cnt <= r_rx_cnt - (RXAW+1)'(1);
            default: r_rx_cnt <= r_rx_cnt;
         endcase
      end
   end

   // ---------------- optional stall timeout ----------------
`ifdef UART_AVM_CTRL_TIMEOUT_EN
   logic [7:0] r_stall_cnt;

   // The counter holds the number of earlier stalled cycles, so 254 here
   // means this is the 255th consecutive stalled cycle.
   assign w_abort = o_busy & avm_waitrequest & (r_stall_cnt == 8'd254);

   always_ff @(posedge avm_clk) begin
      if (avm_rst) begin
         r_stall_cnt <= '0;
         o_timeout   <= 1'b0;
      end else if (w_abort) begin
         r_stall_cnt <= '0;
         o_timeout   <= 1'b1;
      end else if (o_busy & avm_waitrequest) begin
         r_stall_cnt <= r_stall_cnt + 8'd1;
      end else begin
         r_stall_cnt <= '0;
      end
   end
`else
   assign w_abort = 1'b0;
`endif

   // ---------------- control FSM ----------------
   assign w_rx_go = avm_readdata[7] & ~w_rx_full;
   assign w_tx_go = avm_readdata[6] & ~w_tx_empty;

   // Each transfer state raises its request one cycle after entry and drops
   // it on the completing edge, so a request never spans two states.
   always_ff @(posedge avm_clk) begin
      if (avm_rst) begin
         r_state       <= S_IDLE;
         avm_read      <= 1'b0;
         avm_write     <= 1'b0;
         avm_address   <= '0;
         avm_writedata <= '0;
         r_rr_tx       <= 1'b0;
      end else if (w_abort) begin
         avm_read  <= 1'b0;
         avm_write <= 1'b0;
         r_state   <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (~w_rx_full | ~w_tx_empty) r_state <= S_POLL;
            end
            S_POLL: begin
               if (~avm_read) begin
                  avm_read    <= 1'b1;
                  avm_address <= ADDR_STATUS;
               end else if (~avm_waitrequest) begin
                  avm_read <= 1'b0;
                  if (w_rx_go & w_tx_go) begin
                     r_state <= r_rr_tx ? S_TX_WRITE : S_RX_READ;
                     r_rr_tx <= ~r_rr_tx;
                  end else if (w_rx_go) begin
                     r_state <= S_RX_READ;
                  end else if (w_tx_go) begin
                     r_state <= S_TX_WRITE;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            S_RX_READ: begin
               if (~avm_read) begin
                  avm_read    <= 1'b1;
                  avm_address <= ADDR_RX;
               end else if (~avm_waitrequest) begin
                  avm_read <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end
            S_TX_WRITE: begin
               if (~avm_write) begin
                  avm_write     <= 1'b1;
                  avm_address   <= ADDR_TX;
                  avm_writedata <= {24'b0, r_tx_mem[r_tx_rptr]};
               end else if (~avm_waitrequest) begin
                  avm_write <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_avm_ctrl.sv
`timescale 1ns/1ps
module tb_uart_avm_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  avm_address;
   logic        avm_read;
   logic [31:0] avm_readdata;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic        waitreq;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        busy;
`ifdef UART_AVM_CTRL_TIMEOUT_EN
   logic        timeout;
`endif

   logic [31:0] status_val;
   logic [31:0] rxword;

   always #5 clk = ~clk;

   // Slave response: STATUS at address 8, RX data word everywhere else.
   assign avm_readdata = (avm_address == 5'd8) ? status_val : rxword;

   uart_avm_ctrl #(.TX_DEPTH(4), .RX_DEPTH(4)) dut (
      .avm_clk         (clk),
      .avm_rst         (rst),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_readdata    (avm_readdata),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_waitrequest (waitreq),
      .i_tx_data       (tx_data),
      .i_tx_valid      (tx_valid),
      .o_tx_ready      (tx_ready),
      .o_rx_data       (rx_data),
      .o_rx_valid      (rx_valid),
      .i_rx_ready      (rx_ready),
      .o_busy          (busy)
`ifdef UART_AVM_CTRL_TIMEOUT_EN
      ,
      .o_timeout       (timeout)
`endif
   );

   // Completed data transfers: {is_write, address, data}; STATUS polls skipped.
   logic [37:0] log_q [$];
   always @(posedge clk) begin
      if (!rst && (avm_read || avm_write) && !waitreq && avm_address != 5'd8)
         log_q.push_back({avm_write, avm_address, avm_write ? avm_writedata : avm_readdata});
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      int          base;
      int          cnt;
      bit          ok;
      logic [37:0] e;

      rst = 1'b1; waitreq = 1'b0; status_val = 32'h0; rxword = 32'h0;
      tx_data = 8'h0; tx_valid = 1'b0; rx_ready = 1'b0;
      repeat (2) @(negedge clk);

      // reset state
      chk("rst_read",     32'(avm_read), 32'd0);
      chk("rst_write",    32'(avm_write), 32'd0);
      chk("rst_addr",     32'(avm_address), 32'd0);
      chk("rst_wdata",    avm_writedata, 32'd0);
      chk("rst_rx_valid", 32'(rx_valid), 32'd0);
      chk("rst_tx_ready", 32'(tx_ready), 32'd1);
      chk("rst_busy",     32'(busy), 32'd0);
`ifdef UART_AVM_CTRL_TIMEOUT_EN
      chk("rst_timeout",  32'(timeout), 32'd0);
`endif

      // RX path latency: poll assert, complete, data assert, complete
      status_val = 32'h80; rxword = 32'h0000_00A5; rst = 1'b0;
      @(negedge clk);
      chk("poll_entry_read", 32'(avm_read), 32'd0);
      @(negedge clk);
      chk("poll_read",  32'(avm_read), 32'd1);
      chk("poll_addr",  32'(avm_address), 32'd8);
      chk("poll_busy",  32'(busy), 32'd1);
      @(negedge clk);
      chk("poll_done_read", 32'(avm_read), 32'd0);
      chk("poll_done_rxv",  32'(rx_valid), 32'd0);
      @(negedge clk);
      chk("rxrd_read", 32'(avm_read), 32'd1);
      chk("rxrd_addr", 32'(avm_address), 32'd0);
      @(negedge clk);
      chk("rx_valid_a5", 32'(rx_valid), 32'd1);
      chk("rx_data_a5",  32'(rx_data), 32'hA5);
      chk("rxrd_done",   32'(avm_read), 32'd0);
      rxword = 32'h0000_005A;

      // fill RX FIFO, then no more reads while full
      repeat (40) @(negedge clk);
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (avm_read) cnt++;
      end
      chk("rx_full_no_read", cnt, 32'd0);
      status_val = 32'h0;
      rx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("rx_pop_valid", 32'(rx_valid), 32'd1);
         chk("rx_pop_data",  32'(rx_data), (i == 0) ? 32'hA5 : 32'h5A);
         @(negedge clk);
      end
      rx_ready = 1'b0;
      chk("rx_drained", 32'(rx_valid), 32'd0);

      // TX fill with status 0x00: ready drops, nothing written
      for (int i = 0; i < 4; i++) begin
         chk("tx_ready_pre", 32'(tx_ready), 32'd1);
         tx_data = 8'h31 + 8'(i); tx_valid = 1'b1;
         @(negedge clk);
      end
      tx_valid = 1'b0;
      chk("tx_full", 32'(tx_ready), 32'd0);
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (avm_write) cnt++;
      end
      chk("tx_no_write", cnt, 32'd0);

      // TX writes with a 3-cycle stall on the first one
      status_val = 32'h40;
      base = log_q.size();
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (avm_write) ok = 1'b1;
      end
      chk("tx_write_seen", 32'(ok), 32'd1);
      chk("tx_wr_addr0", 32'(avm_address), 32'd4);
      waitreq = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_write", 32'(avm_write), 32'd1);
         chk("stall_addr",  32'(avm_address), 32'd4);
         chk("stall_wdata", avm_writedata, 32'h0000_0031);
      end
      waitreq = 1'b0;
      @(negedge clk);
      chk("stall_done_write", 32'(avm_write), 32'd0);
      chk("single_pop_ready", 32'(tx_ready), 32'd1);
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (log_q.size() >= base + 4) ok = 1'b1;
      end
      chk("tx_all_written", 32'(ok), 32'd1);
      for (int i = 0; i < 4 && ok; i++) begin
         e = log_q[base + i];
         chk("tx_log_kind", 32'(e[37:32]), 32'h24);
         chk("tx_log_data", e[31:0], 32'h31 + 32'(i));
      end

      // round-robin RX/TX alternation from reset
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0; status_val = 32'h0;
      for (int i = 0; i < 4; i++) begin
         tx_data = 8'h41 + 8'(i); tx_valid = 1'b1;
         @(negedge clk);
      end
      tx_valid = 1'b0;
      status_val = 32'hC0; rxword = 32'h0000_0077; rx_ready = 1'b1;
      base = log_q.size();
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (log_q.size() >= base + 4) ok = 1'b1;
      end
      chk("rr_four_xfers", 32'(ok), 32'd1);
      for (int i = 0; i < 4 && ok; i++) begin
         e = log_q[base + i];
         chk("rr_kind", 32'(e[37:32]), (i % 2 == 0) ? 32'h00 : 32'h24);
         chk("rr_data", e[31:0], (i % 2 == 0) ? 32'h77 : (32'h41 + 32'(i / 2)));
      end

      // reset during a stalled STATUS read
      rx_ready = 1'b0;
      repeat (20) @(negedge clk);
      status_val = 32'h0;
      repeat (10) @(negedge clk);
      chk("pre_rst_rx_valid", 32'(rx_valid), 32'd1);
      tx_data = 8'h55; tx_valid = 1'b1;
      for (int i = 0; i < 8 && tx_ready; i++) @(negedge clk);
      tx_valid = 1'b0;
      chk("pre_rst_tx_full", 32'(tx_ready), 32'd0);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (avm_read && avm_address == 5'd8) ok = 1'b1;
      end
      chk("status_rd_seen", 32'(ok), 32'd1);
      waitreq = 1'b1;
      @(negedge clk);
      chk("status_pending", 32'(avm_read), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_read",     32'(avm_read), 32'd0);
      chk("abort_busy",     32'(busy), 32'd0);
      chk("abort_rx_valid", 32'(rx_valid), 32'd0);
      chk("abort_tx_ready", 32'(tx_ready), 32'd1);

`ifdef UART_AVM_CTRL_TIMEOUT_EN
      // stall timeout after 255 cycles of waitrequest
      rst = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (avm_read) ok = 1'b1;
      end
      chk("to_read_seen", 32'(ok), 32'd1);
      repeat (254) @(negedge clk);
      chk("to_not_yet",    32'(timeout), 32'd0);
      chk("to_still_read", 32'(avm_read), 32'd1);
      @(negedge clk);
      chk("to_set",        32'(timeout), 32'd1);
      chk("to_read_drop",  32'(avm_read), 32'd0);
      waitreq = 1'b0;
      repeat (10) @(negedge clk);
      chk("to_sticky",     32'(timeout), 32'd1);
`endif

      rst = 1'b0; waitreq = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
